// File: rtl/switch_debouncer_if.sv
// ----------------------------------------------------------------------------
// switch_debouncer_if
//   Signal bundle between the board-side raw inputs and the debounced outputs.
//
//   Signal semantics (no valid/ready handshake on this bundle):
//     switchesIn  / btnStep   : raw asynchronous levels, may change at any time.
//     switchesOut             : registered debounced levels, always valid.
//     changed / stepPulse     : single-cycle event pulses, no acknowledge; a
//                               consumer that needs them must sample every cycle.
//
//   Modports:
//     master : the side that owns the raw inputs and observes the outputs.
//     slave  : the debouncer itself.
// ----------------------------------------------------------------------------
interface switch_debouncer_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] switchesIn;
  logic             btnStep;
  logic [WIDTH-1:0] switchesOut;
  logic             changed;
  logic             stepPulse;

  modport master (
    output switchesIn,
    output btnStep,
    input  switchesOut,
    input  changed,
    input  stepPulse
  );

  modport slave (
    input  switchesIn,
    input  btnStep,
    output switchesOut,
    output changed,
    output stepPulse
  );
endinterface

// File: rtl/switch_debouncer.sv
// ----------------------------------------------------------------------------
// switch_debouncer
//   Conditions the slide switches and the step pushbutton: two-flop
//   synchroniser per input, a shared free-running sample-tick divider, and a
//   per-bit stability counter. An output bit only flips after STABLE_TICKS
//   consecutive ticks on which the synchronised input disagreed with it.
//
//   Ports:
//     Clk  : system clock, rising edge.
//     Rst  : asynchronous active-low reset.
//     bus  : switch_debouncer_if.slave
//              switchesIn[WIDTH], btnStep      raw inputs
//              switchesOut[WIDTH]              debounced levels (registered)
//              changed                         1-cycle pulse on any output change
//              stepPulse                       1-cycle pulse on debounced press
// ----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  switch_debouncer_if.slave   bus
);

  // Switch bits occupy [WIDTH-1:0]; the step button is bit WIDTH.
  localparam int NB = WIDTH + 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW:0]   CNT_LIM   = (CW + 1)'(STABLE_TICKS);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= {bus.btnStep, bus.switchesIn};
      sync_q  <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Sample-tick divider: free-running from reset release, never restarted
  // by input activity. With TICK_DIV=1 the counter sits at 0 and tick is
  // permanently high.
  // --------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (tick) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-bit stability counters
  // --------------------------------------------------------------------------
  logic [NB-1:0]         stable_q;
  logic [NB-1:0]         stable_d;
  logic [NB-1:0][CW-1:0] cnt_q;
  logic [NB-1:0][CW-1:0] cnt_d;
  logic                  changed_q;
  logic                  changed_d;
  logic                  step_q;
  logic                  step_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (tick) begin
        if (sync_q[i] == stable_q[i]) begin
          // Any agreeing tick breaks the run of disagreement.
          cnt_d[i] = '0;
        end else if (({1'b0, cnt_q[i]} + (CW + 1)'(1)) < CNT_LIM) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end else begin
          // This is the STABLE_TICKS-th consecutive disagreeing tick.
          stable_d[i] = sync_q[i];
          cnt_d[i]    = '0;
        end
      end
    end
    // Pulses are registered so they line up with the new stable value.
    changed_d = (stable_d[WIDTH-1:0] != stable_q[WIDTH-1:0]);
    step_d    = stable_d[WIDTH] & ~stable_q[WIDTH];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stable_q  <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      step_q    <= step_d;
    end
  end

  assign bus.switchesOut = stable_q[WIDTH-1:0];
  assign bus.changed     = changed_q;
  assign bus.stepPulse   = step_q;

endmodule
